// File: rtl/arb_pkg.sv
// Shared types and default sizing for the arbiter requester agent.
package arb_pkg;

   localparam int unsigned DEF_DEPTH   = 4;
   localparam int unsigned DEF_LENW    = 4;
   localparam int unsigned DEF_TIMEOUT = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      OWN  = 2'd2,
      REL  = 2'd3
   } state_t;

endpackage

// File: rtl/arb_requester_if.sv
// Local job intake plus arbiter req/ack handshake and burst status of one requester.
interface arb_requester_if #(
   parameter int unsigned LENW = arb_pkg::DEF_LENW
) ();

   logic            job_valid;
   logic [LENW-1:0] job_len;
   logic            job_ready;
   logic            req;
   logic            ack;
   logic            beat;
   logic            last;
   logic            done;
   logic            err_tmo;
   logic            err_lost;
   logic            busy;

   modport master (
      input  job_valid, job_len, ack,
      output job_ready, req, beat, last, done, err_tmo, err_lost, busy
   );

   modport slave (
      output job_valid, job_len, ack,
      input  job_ready, req, beat, last, done, err_tmo, err_lost, busy
   );

endinterface

// File: rtl/arb_job_fifo.sv
// Small synchronous job FIFO holding burst lengths; head is visible combinationally.
module arb_job_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign rdata   = mem[rd_ptr];

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/arb_requester.sv
// Requester agent: queues burst jobs, runs 4-phase req/ack with the arbiter, issues beats.
module arb_requester
   import arb_pkg::*;
#(
   parameter int unsigned DEPTH   = DEF_DEPTH,
   parameter int unsigned LENW    = DEF_LENW,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic            clk,
   input  logic            rst,
   arb_requester_if.master bus
);

   localparam int unsigned TW = $clog2(TIMEOUT);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   state_t          state_q, state_d;
   logic [LENW-1:0] len_q, len_d;
   logic [LENW-1:0] cnt_q, cnt_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            req_q, req_d;
   logic            done_q, done_d;
   logic            etmo_q, etmo_d;
   logic            elost_q, elost_d;
   logic            pop;
   logic            full;
   logic            empty;
   logic            beat_c;
   logic            last_c;
   logic [LENW-1:0] head;
   logic [CW-1:0]   count;

   arb_job_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (LENW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (bus.job_valid),
      .wdata (bus.job_len),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // Next-state, counters and combinational beat/last.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      req_d   = req_q;
      done_d  = 1'b0;
      etmo_d  = 1'b0;
      elost_d = 1'b0;
      pop     = 1'b0;
      beat_c  = 1'b0;
      last_c  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               len_d   = head;
               req_d   = 1'b1;
               tmo_d   = '0;
               state_d = REQ;
            end
         end
         REQ: begin
            // A grant on the final wait cycle still wins over the timeout.
            if (bus.ack) begin
               cnt_d   = len_q;
               state_d = OWN;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
               req_d   = 1'b0;
               etmo_d  = 1'b1;
               state_d = REL;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         OWN: begin
            if (bus.ack) begin
               beat_c = 1'b1;
               if (cnt_q == '0) begin
                  last_c  = 1'b1;
                  req_d   = 1'b0;
                  done_d  = 1'b1;
                  state_d = REL;
               end else begin
                  cnt_d = cnt_q - LENW'(1);
               end
            end else begin
               req_d   = 1'b0;
               elost_d = 1'b1;
               state_d = REL;
            end
         end
         REL: begin
            req_d = 1'b0;
            if (!bus.ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         tmo_q   <= '0;
         req_q   <= 1'b0;
         done_q  <= 1'b0;
         etmo_q  <= 1'b0;
         elost_q <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         req_q   <= req_d;
         done_q  <= done_d;
         etmo_q  <= etmo_d;
         elost_q <= elost_d;
      end
   end

   assign bus.job_ready = !full;
   assign bus.req       = req_q;
   assign bus.beat      = beat_c;
   assign bus.last      = last_c;
   assign bus.done      = done_q;
   assign bus.err_tmo   = etmo_q;
   assign bus.err_lost  = elost_q;
   assign bus.busy      = (state_q != IDLE) || (count != '0);

endmodule
